ram: RTL and testbench

RAM -- requirements
Module: ram

---
 rtl/ram.sv | 78 +++++++
 tb/tb_ram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// ram: simple dual-port memory, DEPTH words of DATA_WIDTH bits.
//
// One write port and one registered read port, both on the rising edge of
// clock. Reads have one cycle of latency. A read and a write to the same
// address at the same edge return the old contents. Addresses at or above
// DEPTH are ignored on write and read back as zero.
//
// Ports:
//   clock     - single clock, all logic rising-edge triggered
//   reset     - asynchronous, active-high; clears q at once, blocks reads
//               and writes, leaves memory contents untouched
//   data      - write data
//   wraddress - write address
//   wren      - write enable (only a clean 1 writes)
//   rdaddress - read address
//   rden      - read enable; q holds its value while low
//   q         - registered read data
module ram #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] q
);

    // Width of the array index; DEPTH may be smaller than the address space.
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened to ADDR_WIDTH+1 bits so the range check is width-exact
    // even when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DepthLim = DEPTH[ADDR_WIDTH:0];

    // Contents power up as all zeros.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    logic            wr_in_range;
    logic            rd_in_range;
    logic            wr_en;
    logic            rd_en;

    always_comb begin
        wr_idx      = wraddress[IdxW-1:0];
        rd_idx      = rdaddress[IdxW-1:0];
        wr_in_range = ({1'b0, wraddress} < DepthLim);
        rd_in_range = ({1'b0, rdaddress} < DepthLim);
        // Case equality so an X/Z enable never writes or reads in simulation.
        wr_en       = (wren === 1'b1) && !reset;
        rd_en       = (rden === 1'b1);
    end

    // Write port. Reset gates the write but never clears the array, so the
    // array stays a plain RAM without a reset network.
    always_ff @(posedge clock) begin
        if (wr_en && wr_in_range) begin
            mem[wr_idx] <= data;
        end
    end

    // Read port. The non-blocking write above lands after this read samples
    // the array, giving old-data behaviour on a same-address collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (rd_en) begin
            q <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

endmodule

// File: tb/tb_ram.sv
// tb_ram: directed, table-driven bench for ram.
//
// Uses a DEPTH smaller than the address space so the out-of-range rules can
// be exercised. Inputs change 1 ns after a rising edge; q is checked there.
module tb_ram;

    localparam int unsigned DW    = 1;
    localparam int unsigned AW    = 19;
    localparam int unsigned DEPTH = 1500;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data = '0;
    logic [AW-1:0] wraddress = '0;
    logic          wren = 1'b0;
    logic [AW-1:0] rdaddress = '0;
    logic          rden = 1'b0;
    logic [DW-1:0] q;

    int n_checks = 0;
    int n_fail   = 0;

    ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data     (data),
        .wraddress(wraddress),
        .wren     (wren),
        .rdaddress(rdaddress),
        .rden     (rden),
        .q        (q)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         name;
        logic          wren;
        logic [AW-1:0] wa;
        logic [DW-1:0] d;
        logic          rden;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] exp_q);
        n_checks++;
        if (q !== exp_q) begin
            n_fail++;
            $display("FAIL %s: q=%b, expected %b (t=%0t)", name, q, exp_q, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                         input logic re, input logic [AW-1:0] ra);
        wren      = we;
        wraddress = wa;
        data      = d;
        rden      = re;
        rdaddress = ra;
    endtask

    initial begin
        // Power-up: q is zero during reset and after the first read.
        #100;
        check("q_during_powerup_reset", 1'b0);
        #100;
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b1, AW'(5));
        tick();
        check("powerup_read_addr5", 1'b0);

        // Alternating pattern over 0..999.
        for (int a = 0; a < 1000; a++) begin
            drive(1'b1, AW'(a), DW'(a & 1), 1'b0, '0);
            tick();
        end
        for (int a = 0; a < 1000; a++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(a));
            tick();
            check($sformatf("alt_read_%0d", a), DW'(a & 1));
        end

        // Overwrite 0..999 with ones.
        for (int a = 0; a < 1000; a++) begin
            drive(1'b1, AW'(a), 1'b1, 1'b0, '0);
            tick();
        end
        for (int a = 0; a < 1000; a++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(a));
            tick();
            check($sformatf("ovw_read_%0d", a), 1'b1);
        end
        drive(1'b0, '0, '0, 1'b1, AW'(1000));
        tick();
        check("read_unwritten_1000", 1'b0);

        // Single-edge vectors; state carries over from one row to the next.
        vecs.push_back('{"wr7_0",             1'b1, AW'(7),    1'b0, 1'b0, AW'(0),    1'b0});
        vecs.push_back('{"rdw_same_addr_old", 1'b1, AW'(7),    1'b1, 1'b1, AW'(7),    1'b0});
        vecs.push_back('{"rdw_next_edge_new", 1'b0, AW'(0),    1'b0, 1'b1, AW'(7),    1'b1});
        vecs.push_back('{"wr0_0_rd1000",      1'b1, AW'(0),    1'b0, 1'b1, AW'(1000), 1'b0});
        vecs.push_back('{"rd1",               1'b0, AW'(0),    1'b0, 1'b1, AW'(1),    1'b1});
        vecs.push_back('{"rden_low_holds",    1'b0, AW'(0),    1'b0, 1'b0, AW'(0),    1'b1});
        vecs.push_back('{"rd0_after_hold",    1'b0, AW'(0),    1'b0, 1'b1, AW'(0),    1'b0});
        vecs.push_back('{"wr5_0",             1'b1, AW'(5),    1'b0, 1'b1, AW'(1),    1'b1});
        vecs.push_back('{"oor_wr_rd_2053",    1'b1, AW'(2053), 1'b1, 1'b1, AW'(2053), 1'b0});
        vecs.push_back('{"oor_rd_2053",       1'b0, AW'(0),    1'b0, 1'b1, AW'(2053), 1'b0});
        vecs.push_back('{"oor_no_alias_5",    1'b0, AW'(0),    1'b0, 1'b1, AW'(5),    1'b0});
        vecs.push_back('{"wr1499_1_rd1",      1'b1, AW'(1499), 1'b1, 1'b1, AW'(1),    1'b1});
        vecs.push_back('{"rd_last_1499",      1'b0, AW'(0),    1'b0, 1'b1, AW'(1499), 1'b1});
        vecs.push_back('{"oor_wr1500_rd1499", 1'b1, AW'(1500), 1'b0, 1'b1, AW'(1499), 1'b1});
        vecs.push_back('{"oor_rd_1500",       1'b0, AW'(0),    1'b0, 1'b1, AW'(1500), 1'b0});
        vecs.push_back('{"diff_addr_wr10_rd11", 1'b1, AW'(10), 1'b0, 1'b1, AW'(11),   1'b1});
        vecs.push_back('{"rd10_after_wr",     1'b0, AW'(0),    1'b0, 1'b1, AW'(10),   1'b0});
        vecs.push_back('{"x_wren_wr12",       1'bx, AW'(12),   1'b0, 1'b1, AW'(11),   1'b1});
        vecs.push_back('{"rd12_untouched",    1'b0, AW'(0),    1'b0, 1'b1, AW'(12),   1'b1});

        foreach (vecs[i]) begin
            drive(vecs[i].wren, vecs[i].wa, vecs[i].d, vecs[i].rden, vecs[i].ra);
            tick();
            check(vecs[i].name, vecs[i].exp_q);
        end

        // Inputs changing between edges must not matter: q sampled rdaddress=1.
        drive(1'b0, '0, '0, 1'b1, AW'(0));
        #2;
        rdaddress = AW'(1);
        tick();
        check("between_edge_change_rd1", 1'b1);

        // Async reset mid-operation with a blocked write to address 3.
        drive(1'b0, '0, '0, 1'b1, AW'(3));
        tick();
        check("pre_reset_rd3", 1'b1);
        #2;
        reset = 1'b1;
        drive(1'b1, AW'(3), 1'b0, 1'b1, AW'(3));
        #1;
        check("reset_clears_q_immediately", 1'b0);
        tick();
        tick();
        check("q_zero_while_reset", 1'b0);
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b1, AW'(3));
        tick();
        check("rd3_after_reset_retained", 1'b1);

        // Reset mid-burst: writes of 0 to 20..24 land, 25..29 are blocked.
        for (int a = 20; a < 30; a++) begin
            if (a == 25) begin
                #2;
                reset = 1'b1;
            end
            drive(1'b1, AW'(a), 1'b0, 1'b0, '0);
            tick();
        end
        #2;
        reset = 1'b0;
        for (int a = 20; a < 31; a++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(a));
            tick();
            check($sformatf("burst_reset_rd_%0d", a), (a < 25) ? 1'b0 : 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

endmodule
